// File: rtl/adc_frame_sequencer.sv
// adc_frame_sequencer: arms the ADC capture engine, acknowledges its end-of-frame requests
// and spaces frames by a fixed gap. Optional CAPTURE watchdog/ERR path: ADC_SEQ_TIMEOUT_EN.
module adc_frame_sequencer #(
  parameter int unsigned FRAME_CNT_W    = 8,
  parameter int unsigned GAP_CYCLES     = 200,
  parameter int unsigned ACK_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16384
) (
  input  logic                   clk_200MHz_i,
  input  logic                   reset_n,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic [FRAME_CNT_W-1:0] frames_req_i,
  input  logic                   frame_done_req_i,
  output logic                   adc_arm_o,
  output logic                   frame_end_rst_o,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o,
  output logic                   busy_o,
  output logic                   done_o
`ifdef ADC_SEQ_TIMEOUT_EN
  ,
  output logic                   timeout_o
`endif
);

  localparam int unsigned MAX_GA  = (GAP_CYCLES > ACK_CYCLES) ? GAP_CYCLES : ACK_CYCLES;
  localparam int unsigned MAX_ALL = (MAX_GA > TIMEOUT_CYCLES) ? MAX_GA : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_ALL + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_CAPTURE = 3'd2,
    S_ACK     = 3'd3,
    S_GAP     = 3'd4,
    S_DONE    = 3'd5
`ifdef ADC_SEQ_TIMEOUT_EN
    ,
    S_ERR     = 3'd6
`endif
  } state_e;

  state_e                 state_q;
  logic [FRAME_CNT_W-1:0] tgt_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   stop_pend_q;
  logic                   evt_hold_q;
  logic                   adc_arm_q;
  logic                   frame_end_rst_q;
  logic                   busy_q;
  logic                   done_q;
`ifdef ADC_SEQ_TIMEOUT_EN
  logic                   timeout_q;
`endif

  logic req_meta_q;
  logic req_sync_q;
  logic req_prev_q;
  logic frame_evt_q;

  logic evt_c;
  logic stop_now_c;
  logic last_frame_c;

  // Bring the 10 MHz-domain request across and turn its rising edge into a 1-cycle event
  always_ff @(posedge clk_200MHz_i or negedge reset_n) begin
    if (!reset_n) begin
      req_meta_q  <= 1'b0;
      req_sync_q  <= 1'b0;
      req_prev_q  <= 1'b0;
      frame_evt_q <= 1'b0;
    end else begin
      req_meta_q  <= frame_done_req_i;
      req_sync_q  <= req_meta_q;
      req_prev_q  <= req_sync_q;
      frame_evt_q <= req_sync_q & ~req_prev_q;
    end
  end

  assign evt_c        = frame_evt_q | evt_hold_q;
  assign stop_now_c   = stop_pend_q | stop_i;
  assign last_frame_c = (tgt_q != '0) && (frame_cnt_q == tgt_q);

  // Sequencer FSM; every output is set on the transition into the state that owns it
  always_ff @(posedge clk_200MHz_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      tgt_q           <= '0;
      frame_cnt_q     <= '0;
      cnt_q           <= '0;
      stop_pend_q     <= 1'b0;
      evt_hold_q      <= 1'b0;
      adc_arm_q       <= 1'b0;
      frame_end_rst_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
      timeout_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (busy_q && stop_i) begin
        stop_pend_q <= 1'b1;
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            tgt_q       <= frames_req_i;
            frame_cnt_q <= '0;
            stop_pend_q <= stop_i;
            adc_arm_q   <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_ARM;
`ifdef ADC_SEQ_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
          end
        end

        // An event landing during the single ARM cycle is held for CAPTURE
        S_ARM: begin
          adc_arm_q  <= 1'b0;
          evt_hold_q <= frame_evt_q;
          cnt_q      <= '0;
          state_q    <= S_CAPTURE;
        end

        S_CAPTURE: begin
          if (evt_c) begin
            evt_hold_q      <= 1'b0;
            frame_cnt_q     <= FRAME_CNT_W'(frame_cnt_q + 1'b1);
            frame_end_rst_q <= 1'b1;
            cnt_q           <= '0;
            state_q         <= S_ACK;
          end
`ifdef ADC_SEQ_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            frame_end_rst_q <= 1'b1;
            timeout_q       <= 1'b1;
            cnt_q           <= '0;
            state_q         <= S_ERR;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`endif
        end

        S_ACK: begin
          if (cnt_q == CNT_W'(ACK_CYCLES - 1)) begin
            frame_end_rst_q <= 1'b0;
            cnt_q           <= '0;
            state_q         <= S_GAP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        // A stop arriving on the final gap cycle is honoured immediately
        S_GAP: begin
          if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
            cnt_q <= '0;
            if (stop_now_c || last_frame_c) begin
              done_q      <= 1'b1;
              busy_q      <= 1'b0;
              stop_pend_q <= 1'b0;
              state_q     <= S_DONE;
            end else begin
              adc_arm_q <= 1'b1;
              state_q   <= S_ARM;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

`ifdef ADC_SEQ_TIMEOUT_EN
        S_ERR: begin
          if (cnt_q == CNT_W'(ACK_CYCLES - 1)) begin
            frame_end_rst_q <= 1'b0;
            cnt_q           <= '0;
            done_q          <= 1'b1;
            busy_q          <= 1'b0;
            stop_pend_q     <= 1'b0;
            state_q         <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`endif

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign adc_arm_o       = adc_arm_q;
  assign frame_end_rst_o = frame_end_rst_q;
  assign frame_cnt_o     = frame_cnt_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
`ifdef ADC_SEQ_TIMEOUT_EN
  assign timeout_o       = timeout_q;
`endif

endmodule

// File: tb/tb_adc_frame_sequencer.sv
// Scoreboard bench for adc_frame_sequencer: expected done results are queued at start,
// a monitor pops them on done_o and also checks pulse widths and inter-frame gaps.
`timescale 1ns/100ps
module tb_adc_frame_sequencer;

  localparam int unsigned FW  = 8;
  localparam int unsigned GAP = 200;
  localparam int unsigned ACK = 4;
  localparam int unsigned TMO = 16384;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start_i;
  logic          stop_i;
  logic [FW-1:0] frames_req_i;
  logic          frame_done_req_i;
  logic          adc_arm_o;
  logic          frame_end_rst_o;
  logic [FW-1:0] frame_cnt_o;
  logic          busy_o;
  logic          done_o;
`ifdef ADC_SEQ_TIMEOUT_EN
  logic          timeout_o;
`endif

  logic resp_req = 1'b0;
  logic man_req  = 1'b0;
  bit   resp_en   = 1'b0;
  bit   gap_extra = 1'b0;

  assign frame_done_req_i = resp_req | man_req;

  always #2.5 clk = ~clk;

  adc_frame_sequencer #(
    .FRAME_CNT_W   (FW),
    .GAP_CYCLES    (GAP),
    .ACK_CYCLES    (ACK),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_200MHz_i    (clk),
    .reset_n         (reset_n),
    .start_i         (start_i),
    .stop_i          (stop_i),
    .frames_req_i    (frames_req_i),
    .frame_done_req_i(frame_done_req_i),
    .adc_arm_o       (adc_arm_o),
    .frame_end_rst_o (frame_end_rst_o),
    .frame_cnt_o     (frame_cnt_o),
    .busy_o          (busy_o),
    .done_o          (done_o)
`ifdef ADC_SEQ_TIMEOUT_EN
    ,
    .timeout_o       (timeout_o)
`endif
  );

  typedef struct {
    logic [FW-1:0] cnt;
    logic          tmo;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event not seen within cycle budget", nm);
  endtask

  // Monitor: done_o pops the scoreboard; arm/ack pulse widths and gaps checked on the fly
  int   arm_cnt = 0, rst_cnt = 0, done_cnt = 0;
  int   arm_w = 0, rst_w = 0, gap_len = 0;
  bit   in_gap = 1'b0;
  logic arm_p = 1'b0, rst_p = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      in_gap = 1'b0;
      arm_p  = 1'b0;
      rst_p  = 1'b0;
    end else begin
      if (adc_arm_o && !arm_p) begin
        arm_cnt++;
        arm_w = 1;
        if (in_gap) chk("gap_len", gap_len, GAP);
        in_gap = 1'b0;
      end else if (adc_arm_o) begin
        arm_w++;
      end else if (arm_p) begin
        chk("arm_width", arm_w, 1);
      end

      if (frame_end_rst_o && !rst_p) begin
        rst_cnt++;
        rst_w = 1;
      end else if (frame_end_rst_o) begin
        rst_w++;
      end else if (rst_p) begin
        chk("ack_width", rst_w, ACK);
        in_gap  = 1'b1;
        gap_len = 1;
      end else if (in_gap && !adc_arm_o) begin
        gap_len++;
      end

      if (done_o) begin
        exp_t e;
        done_cnt++;
        in_gap = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: actual frame_cnt=%0d expected no done", frame_cnt_o);
        end else begin
          e = exp_q.pop_front();
          chk("done_frame_cnt", int'(frame_cnt_o), int'(e.cnt));
          chk("done_busy", int'(busy_o), 0);
`ifdef ADC_SEQ_TIMEOUT_EN
          chk("done_timeout", int'(timeout_o), int'(e.tmo));
`endif
        end
      end
      arm_p = adc_arm_o;
      rst_p = frame_end_rst_o;
    end
  end

  // Capture-engine model: end-of-frame request 20 clk after each arm, optional stray pulse in GAP
  initial begin
    forever begin
      @(negedge clk);
      if (resp_en && adc_arm_o) begin
        repeat (20) @(negedge clk);
        resp_req = 1'b1;
        repeat (4) @(negedge clk);
        resp_req = 1'b0;
        if (gap_extra) begin
          repeat (60) @(negedge clk);
          resp_req = 1'b1;
          repeat (4) @(negedge clk);
          resp_req = 1'b0;
        end
      end
    end
  end

  task automatic push_exp(input int cnt, input bit tmo);
    exp_t e;
    e.cnt = FW'(cnt);
    e.tmo = tmo;
    exp_q.push_back(e);
  endtask

  task automatic start_seq(input int n, input bit stp);
    frames_req_i = FW'(n);
    start_i      = 1'b1;
    stop_i       = stp;
    @(negedge clk);
    start_i = 1'b0;
    stop_i  = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int maxc);
    int d0 = done_cnt;
    int k  = 0;
    while (done_cnt == d0 && k < maxc) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt == d0) fail_now(nm);
  endtask

  task automatic wait_arms(input string nm, input int target, input int maxc);
    int k = 0;
    while (arm_cnt < target && k < maxc) begin
      @(negedge clk);
      k++;
    end
    if (arm_cnt < target) fail_now(nm);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_arm"}, int'(adc_arm_o), 0);
    chk({nm, "_ack"}, int'(frame_end_rst_o), 0);
    chk({nm, "_cnt"}, int'(frame_cnt_o), 0);
    chk({nm, "_busy"}, int'(busy_o), 0);
    chk({nm, "_done"}, int'(done_o), 0);
  endtask

  int base;
  int rbase;
  int n;

  initial begin
    reset_n      = 1'b0;
    start_i      = 1'b0;
    stop_i       = 1'b0;
    frames_req_i = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
`ifdef ADC_SEQ_TIMEOUT_EN
    chk("reset_timeout", int'(timeout_o), 0);
`endif
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Three-frame sequence
    resp_en = 1'b1;
    base  = arm_cnt;
    rbase = rst_cnt;
    push_exp(3, 1'b0);
    start_seq(3, 1'b0);
    chk("busy_after_start", int'(busy_o), 1);
    wait_done("done_3frames", 3000);
    chk("arms_3frames", arm_cnt - base, 3);
    chk("acks_3frames", rst_cnt - rbase, 3);

    // Stray request while IDLE is ignored
    @(negedge clk);
    man_req = 1'b1;
    repeat (4) @(negedge clk);
    man_req = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_evt_cnt", int'(frame_cnt_o), 3);
    chk("idle_evt_busy", int'(busy_o), 0);

    // Stray request in GAP is ignored
    gap_extra = 1'b1;
    base = arm_cnt;
    push_exp(2, 1'b0);
    start_seq(2, 1'b0);
    wait_done("done_gap_evt", 3000);
    chk("arms_gap_evt", arm_cnt - base, 2);
    gap_extra = 1'b0;
    repeat (5) @(negedge clk);

    // Continuous run stopped during frame 5 capture
    base = arm_cnt;
    push_exp(5, 1'b0);
    start_seq(0, 1'b0);
    wait_arms("arm5_cont", base + 5, 3000);
    repeat (5) @(negedge clk);
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    wait_done("done_cont_stop", 1000);
    chk("arms_cont_stop", arm_cnt - base, 5);
    repeat (5) @(negedge clk);

    // Start while busy is ignored
    base = arm_cnt;
    push_exp(2, 1'b0);
    start_seq(2, 1'b0);
    repeat (50) @(negedge clk);
    start_seq(7, 1'b0);
    wait_done("done_busy_start", 3000);
    chk("arms_busy_start", arm_cnt - base, 2);
    repeat (5) @(negedge clk);

    // Start and stop together: exactly one frame
    base = arm_cnt;
    push_exp(1, 1'b0);
    start_seq(4, 1'b1);
    wait_done("done_start_stop", 1000);
    chk("arms_start_stop", arm_cnt - base, 1);
    repeat (5) @(negedge clk);

    // Reset in the middle of frame 2 capture, then a normal single frame
    base = arm_cnt;
    start_seq(3, 1'b0);
    wait_arms("arm2_reset", base + 2, 1000);
    repeat (5) @(negedge clk);
    chk("pre_reset_cnt", int'(frame_cnt_o), 1);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1 chk_all_zero("midreset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_reset_busy", int'(busy_o), 0);
    push_exp(1, 1'b0);
    start_seq(1, 1'b0);
    wait_done("done_after_reset", 1000);
    repeat (5) @(negedge clk);

`ifdef ADC_SEQ_TIMEOUT_EN
    // Capture watchdog: no end-of-frame request ever arrives
    resp_en = 1'b0;
    push_exp(0, 1'b1);
    start_seq(1, 1'b0);
    n = 0;
    while (!adc_arm_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!timeout_o && n < int'(TMO) + 100) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_latency", n, int'(TMO) + 1);
    wait_done("done_timeout", 100);
    repeat (3) @(negedge clk);
    chk("timeout_held", int'(timeout_o), 1);
    resp_en = 1'b1;
    push_exp(1, 1'b0);
    start_seq(1, 1'b0);
    chk("timeout_cleared", int'(timeout_o), 0);
    wait_done("done_after_timeout", 1000);
    repeat (5) @(negedge clk);
`endif

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
